// File: rtl/load_store_unit.sv
// Load/store unit: one memory access at a time over a req/gnt/rvalid bus.
// Handles lane steering, load extension, alignment faults and bus timeouts.
module load_store_unit #(
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  load_op,
  input  logic [2:0]  store_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] fault_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Operation encodings shared with the decoder's params.vh
  localparam logic [2:0] LD_BYTE_S = 3'd0;
  localparam logic [2:0] LD_HALF_S = 3'd1;
  localparam logic [2:0] LD_WORD   = 3'd2;
  localparam logic [2:0] LD_BYTE_U = 3'd4;
  localparam logic [2:0] LD_HALF_U = 3'd5;
  localparam logic [2:0] ST_BYTE   = 3'd0;
  localparam logic [2:0] ST_HALF   = 3'd1;
  localparam logic [2:0] ST_WORD   = 3'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic          write_q, write_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;
  logic [31:0]   fault_addr_q, fault_addr_d;

  logic [1:0]    req_size;
  logic          req_sext;
  logic          req_misaligned;
  logic          accept;
  logic [31:0]   st_data;
  logic [3:0]    st_be;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_result;
  logic          timed_out;

  // Unknown op codes fall through to word size so they get the strictest alignment check.
  always_comb begin
    req_size = SZ_WORD;
    req_sext = 1'b0;
    if (req_write) begin
      case (store_op)
        ST_BYTE: req_size = SZ_BYTE;
        ST_HALF: req_size = SZ_HALF;
        ST_WORD: req_size = SZ_WORD;
        default: req_size = SZ_WORD;
      endcase
    end else begin
      case (load_op)
        LD_BYTE_S: begin req_size = SZ_BYTE; req_sext = 1'b1; end
        LD_BYTE_U: req_size = SZ_BYTE;
        LD_HALF_S: begin req_size = SZ_HALF; req_sext = 1'b1; end
        LD_HALF_U: req_size = SZ_HALF;
        LD_WORD:   req_size = SZ_WORD;
        default:   req_size = SZ_WORD;
      endcase
    end
  end

  assign req_misaligned = ((req_size == SZ_HALF) && addr[0]) ||
                          ((req_size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign accept = (state_q == S_IDLE) && req_valid && !req_misaligned;

  always_comb begin
    st_data = wdata;
    st_be   = 4'b1111;
    case (req_size)
      SZ_BYTE: begin
        st_data = {4{wdata[7:0]}};
        st_be   = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        st_data = {2{wdata[15:0]}};
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Lane select and extension for the returning load word.
  always_comb begin
    lane_byte = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_byte = mem_rdata[7:0];
      2'd1: lane_byte = mem_rdata[15:8];
      2'd2: lane_byte = mem_rdata[23:16];
      2'd3: lane_byte = mem_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_result = {{24{sext_q & lane_byte[7]}}, lane_byte};
      SZ_HALF: load_result = {{16{sext_q & lane_half[15]}}, lane_half};
      default: load_result = mem_rdata;
    endcase
  end

  assign timed_out = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sext_d       = sext_q;
    write_d      = write_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    rdata_d      = rdata_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_misaligned) begin
          state_d      = S_DONE;
          misalign_d   = 1'b1;
          bus_err_d    = 1'b0;
          fault_addr_d = addr;
          rdata_d      = 32'h0;
        end else if (accept) begin
          state_d     = S_REQ;
          cnt_d       = '0;
          addr_d      = addr;
          size_d      = req_size;
          sext_d      = req_sext;
          write_d     = req_write;
          mem_we_d    = req_write;
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_wdata_d = req_write ? st_data : 32'h0;
          mem_be_d    = req_write ? st_be : 4'b1111;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timed_out) begin
          state_d      = S_DONE;
          bus_err_d    = 1'b1;
          fault_addr_d = addr_q;
          rdata_d      = 32'h0;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the last allowed cycle still counts as completion.
        if (mem_rvalid) begin
          state_d = S_DONE;
          rdata_d = write_q ? 32'h0 : load_result;
        end else if (timed_out) begin
          state_d      = S_DONE;
          bus_err_d    = 1'b1;
          fault_addr_d = addr_q;
          rdata_d      = 32'h0;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        rdata_d      = 32'h0;
        misalign_d   = 1'b0;
        bus_err_d    = 1'b0;
        fault_addr_d = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= 32'h0;
      size_q       <= SZ_WORD;
      sext_q       <= 1'b0;
      write_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'b0000;
      rdata_q      <= 32'h0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sext_q       <= sext_d;
      write_q      <= write_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign busy       = accept || (state_q == S_REQ) || (state_q == S_WAIT);
  assign done       = (state_q == S_DONE);
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses, responses checked
// by a monitor whenever done or a granted bus request appears.
module tb_load_store_unit;

  localparam int BUS_TO = 8;

  localparam logic [2:0] LD_BYTE_S = 3'd0;
  localparam logic [2:0] LD_HALF_S = 3'd1;
  localparam logic [2:0] LD_WORD   = 3'd2;
  localparam logic [2:0] LD_BYTE_U = 3'd4;
  localparam logic [2:0] LD_HALF_U = 3'd5;
  localparam logic [2:0] ST_BYTE   = 3'd0;
  localparam logic [2:0] ST_HALF   = 3'd1;
  localparam logic [2:0] ST_WORD   = 3'd2;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        berr;
    logic [31:0] fault;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  load_op;
  logic [2:0]  store_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        bus_err;
  logic [31:0] fault_addr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  resp_t respQ[$];
  bus_t  busQ[$];
  int    checks = 0;
  int    failures = 0;

  load_store_unit #(.BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .load_op(load_op), .store_op(store_op),
    .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .fault_addr(fault_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations when the DUT completes or a request is granted,
  // and verifies request fields do not move while the bus stalls.
  logic        prevReq = 1'b0;
  logic        prevGnt = 1'b0;
  logic        prevWe;
  logic [31:0] prevAddr;
  logic [31:0] prevWdata;
  logic [3:0]  prevBe;

  always @(negedge clk) begin
    resp_t r;
    bus_t  b;
    if (done) begin
      if (respQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        r = respQ.pop_front();
        checkOutput("resp_rdata", rdata, r.rdata);
        checkOutput("resp_misalign", {31'h0, misalign}, {31'h0, r.mis});
        checkOutput("resp_bus_err", {31'h0, bus_err}, {31'h0, r.berr});
        if (r.mis || r.berr) checkOutput("resp_fault_addr", fault_addr, r.fault);
      end
    end
    if (mem_req && mem_gnt) begin
      if (busQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_grant: got granted request, expected none");
      end else begin
        b = busQ.pop_front();
        checkOutput("bus_we", {31'h0, mem_we}, {31'h0, b.we});
        checkOutput("bus_addr", mem_addr, b.addr);
        checkOutput("bus_be", {28'h0, mem_be}, {28'h0, b.be});
        if (b.we) checkOutput("bus_wdata", mem_wdata, b.wdata);
      end
    end
    if (mem_req && prevReq && !prevGnt) begin
      checkOutput("stall_addr", mem_addr, prevAddr);
      checkOutput("stall_wdata", mem_wdata, prevWdata);
      checkOutput("stall_be", {28'h0, mem_be}, {28'h0, prevBe});
      checkOutput("stall_we", {31'h0, mem_we}, {31'h0, prevWe});
    end
    if (misalign && bus_err) checkOutput("mis_and_berr", 32'h1, 32'h0);
    prevReq   = mem_req;
    prevGnt   = mem_gnt;
    prevWe    = mem_we;
    prevAddr  = mem_addr;
    prevWdata = mem_wdata;
    prevBe    = mem_be;
  end

  // Issues one access starting at posedge+1 in IDLE and plays the bus side.
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] wd, input int gntDelay,
                               input logic [31:0] busWord, input logic expMis, input logic expBerr,
                               input logic [3:0] expBe, input logic [31:0] expMemWdata,
                               input logic [31:0] expRdata);
    resp_t r;
    bus_t  b;
    int    cycles;
    req_valid = 1'b1;
    req_write = wr;
    load_op   = wr ? 3'd0 : op;
    store_op  = wr ? op : 3'd0;
    addr      = a;
    wdata     = wd;
    r.rdata = expRdata;
    r.mis   = expMis;
    r.berr  = expBerr;
    r.fault = a;
    respQ.push_back(r);
    if (!expMis && !expBerr) begin
      b.we = wr;
      b.addr = {a[31:2], 2'b00};
      b.wdata = expMemWdata;
      b.be = expBe;
      busQ.push_back(b);
    end
    #1;
    checkOutput({tag, "_busy_issue"}, {31'h0, busy}, {31'h0, !expMis});
    @(posedge clk); #1;
    req_valid = 1'b0;
    addr      = 32'hDEAD_0000;
    wdata     = 32'h0BAD_0BAD;
    #1;
    if (expMis) begin
      checkOutput({tag, "_mis_done"}, {31'h0, done}, 32'h1);
      checkOutput({tag, "_mis_busy"}, {31'h0, busy}, 32'h0);
      checkOutput({tag, "_mis_req"}, {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      checkOutput({tag, "_mis_idle"}, {31'h0, done}, 32'h0);
    end else if (expBerr) begin
      cycles = 0;
      while (!done && cycles < 100) begin
        @(posedge clk); #1;
        cycles++;
      end
      checkOutput({tag, "_to_cycles"}, cycles, BUS_TO);
      checkOutput({tag, "_to_req"}, {31'h0, mem_req}, 32'h0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h1357_9BDF;
      @(posedge clk); #1;
      checkOutput({tag, "_late1_done"}, {31'h0, done}, 32'h0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      checkOutput({tag, "_late2_done"}, {31'h0, done}, 32'h0);
      checkOutput({tag, "_late2_busy"}, {31'h0, busy}, 32'h0);
    end else begin
      checkOutput({tag, "_req"}, {31'h0, mem_req}, 32'h1);
      checkOutput({tag, "_busy_req"}, {31'h0, busy}, 32'h1);
      repeat (gntDelay) begin
        @(posedge clk); #1;
      end
      checkOutput({tag, "_req_held"}, {31'h0, mem_req}, 32'h1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      #1;
      checkOutput({tag, "_wait_req"}, {31'h0, mem_req}, 32'h0);
      checkOutput({tag, "_busy_wait"}, {31'h0, busy}, 32'h1);
      mem_rvalid = 1'b1;
      mem_rdata  = busWord;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h5A5A_5A5A;
      #1;
      checkOutput({tag, "_done"}, {31'h0, done}, 32'h1);
      checkOutput({tag, "_busy_done"}, {31'h0, busy}, 32'h0);
      @(posedge clk); #1;
      checkOutput({tag, "_idle"}, {31'h0, done}, 32'h0);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
    checkOutput({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
    checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
    checkOutput({tag, "_misalign"}, {31'h0, misalign}, 32'h0);
    checkOutput({tag, "_bus_err"}, {31'h0, bus_err}, 32'h0);
    checkOutput({tag, "_rdata"}, rdata, 32'h0);
    checkOutput({tag, "_fault_addr"}, fault_addr, 32'h0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'h0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    checkOutput({tag, "_mem_be"}, {28'h0, mem_be}, 32'h0);
  endtask

  initial begin
    bus_t b;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    load_op = 3'd0;
    store_op = 3'd0;
    addr = 32'h0;
    wdata = 32'h0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    //            tag      wr    op         addr          wdata          gd  busWord        mis   berr  be       memWdata       rdata
    applyStimulus("ld_bs", 1'b0, LD_BYTE_S, 32'h0000_1003, 32'h0,        0, 32'h80FF_FF11, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hFFFF_FF80);
    applyStimulus("st_h",  1'b1, ST_HALF,   32'h0000_2002, 32'h1234_ABCD, 0, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0);
    applyStimulus("ld_wm", 1'b0, LD_WORD,   32'h0000_3001, 32'h0,        0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0);
    applyStimulus("ld_hu", 1'b0, LD_HALF_U, 32'h0000_0002, 32'h0,        3, 32'hF00D_1234, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h0000_F00D);
    applyStimulus("st_b",  1'b1, ST_BYTE,   32'h0000_4001, 32'h0000_00A5, 2, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    applyStimulus("st_w",  1'b1, ST_WORD,   32'h0000_5000, 32'hDEAD_BEEF, 1, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    applyStimulus("ld_hs", 1'b0, LD_HALF_S, 32'h0000_6002, 32'h0,        0, 32'h8001_7FFF, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hFFFF_8001);
    applyStimulus("ld_bu", 1'b0, LD_BYTE_U, 32'h0000_7002, 32'h0,        0, 32'h12C3_5678, 1'b0, 1'b0, 4'b1111, 32'h0,         32'h0000_00C3);
    applyStimulus("ld_hm", 1'b0, LD_HALF_S, 32'h0000_8001, 32'h0,        0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0);
    applyStimulus("st_hm", 1'b1, ST_HALF,   32'h0000_8003, 32'h1111_2222, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,         32'h0);
    applyStimulus("ld_xm", 1'b0, 3'd3,      32'h0000_9002, 32'h0,        0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0);
    applyStimulus("ld_x",  1'b0, 3'd7,      32'h0000_9004, 32'h0,        0, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hCAFE_F00D);
    applyStimulus("st_xm", 1'b1, 3'd5,      32'h0000_9006, 32'h0,        0, 32'h0,         1'b1, 1'b0, 4'b0000, 32'h0,         32'h0);
    applyStimulus("ld_to", 1'b0, LD_WORD,   32'h0000_A000, 32'h0,        0, 32'h0,         1'b0, 1'b1, 4'b0000, 32'h0,         32'h0);

    // Reset in WAIT aborts the access; the stray response must not complete anything.
    req_valid = 1'b1;
    req_write = 1'b0;
    load_op   = LD_WORD;
    addr      = 32'h0000_B004;
    b.we = 1'b0;
    b.addr = 32'h0000_B004;
    b.wdata = 32'h0;
    b.be = 4'b1111;
    busQ.push_back(b);
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkResetState("abort");
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checkOutput("abort_stray_done", {31'h0, done}, 32'h0);
    checkOutput("abort_stray_rdata", rdata, 32'h0);
    applyStimulus("ld_post", 1'b0, LD_WORD, 32'h0000_B000, 32'h0, 0, 32'h0123_4567, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0123_4567);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("respQ_empty", respQ.size(), 32'h0);
    checkOutput("busQ_empty", busQ.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
